// File: rtl/memory_access_if.sv
// -----------------------------------------------------------------------------
// memory_access_if
// Data-memory bus between the memory-access pipeline stage and data memory.
//
// Signals:
//   dreq_valid   request to data memory (held until dresp_ack)
//   dreq_addr    8-byte-aligned request address
//   dreq_write   1 = store, 0 = load
//   dreq_strobe  byte enables for the aligned word
//   dreq_wdata   store data shifted into its byte lanes
//   dresp_ack    one-cycle completion pulse from memory
//   dresp_rdata  aligned read word, valid with dresp_ack
//
// Modports:
//   master  pipeline stage side (drives requests, receives responses)
//   slave   memory side
// -----------------------------------------------------------------------------
interface memory_access_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  dreq_valid;
  logic [ADDR_W-1:0]     dreq_addr;
  logic                  dreq_write;
  logic [DATA_W/8-1:0]   dreq_strobe;
  logic [DATA_W-1:0]     dreq_wdata;
  logic                  dresp_ack;
  logic [DATA_W-1:0]     dresp_rdata;

  modport master (
    output dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_wdata,
    input  dresp_ack, dresp_rdata
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_wdata,
    output dresp_ack, dresp_rdata
  );
endinterface

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
// Memory-access pipeline stage sitting just upstream of writeback. On each
// global advance it latches the EX/MEM payload, issues at most one data-memory
// request for that instruction, aligns load data (sign/zero extension) and
// store data (byte strobes), and presents the result to the MEM/WB register.
// While a request is outstanding ok_to_proceed is held low to stall the
// whole pipeline.
//
// Optional feature: define MISALIGN_TRAP_EN to flag accesses not aligned to
// their size (no request is issued, out_misaligned=1). Without it,
// out_misaligned is 0 and misaligned accesses go out with a truncated strobe.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   ok_to_proceed_overall    global advance; latch new payload this edge
//   ok_to_proceed            this stage is ready to advance
//   in_*                     EX/MEM payload (valid, isMem, isMemRead, size,
//                            unsigned, memAddr, storeData)
//   dmem                     data-memory bus (memory_access_if.master)
//   out_*                    MEM/WB payload (valid, memOut, memAddr,
//                            misaligned)
// -----------------------------------------------------------------------------
module memory_access #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ok_to_proceed_overall,
  output logic                ok_to_proceed,
  input  logic                in_valid,
  input  logic                in_isMem,
  input  logic                in_isMemRead,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [ADDR_W-1:0]   in_memAddr,
  input  logic [DATA_W-1:0]   in_storeData,
  memory_access_if.master     dmem,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_memOut,
  output logic [ADDR_W-1:0]   out_memAddr,
  output logic                out_misaligned
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state_q, state_d;
  logic                ok_q, ok_d;
  logic                dreq_valid_q, dreq_valid_d;
  logic [ADDR_W-1:0]   dreq_addr_q, dreq_addr_d;
  logic                dreq_write_q, dreq_write_d;
  logic [STRB_W-1:0]   dreq_strobe_q, dreq_strobe_d;
  logic [DATA_W-1:0]   dreq_wdata_q, dreq_wdata_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   mem_out_q, mem_out_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                misaligned_q, misaligned_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;

  logic [OFF_W-1:0]    in_off;
  logic                misaligned;
  logic [STRB_W-1:0]   strobe_base;
  logic [DATA_W-1:0]   rdata_shifted;
  logic [DATA_W-1:0]   load_ext;

  assign in_off = in_memAddr[OFF_W-1:0];

  // Misalignment check on the incoming payload; only meaningful with the trap
  // feature enabled, otherwise misaligned accesses are simply issued.
  always_comb begin
    misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
    case (in_size)
      2'd1:    misaligned = in_off[0];
      2'd2:    misaligned = |in_off[1:0];
      2'd3:    misaligned = |in_off;
      default: misaligned = 1'b0;
    endcase
`endif
  end

  // Unshifted byte-enable pattern for the access size.
  always_comb begin
    strobe_base = '0;
    case (in_size)
      2'd0:    strobe_base = STRB_W'(8'h01);
      2'd1:    strobe_base = STRB_W'(8'h03);
      2'd2:    strobe_base = STRB_W'(8'h0F);
      default: strobe_base = STRB_W'(8'hFF);
    endcase
  end

  // Load alignment uses the latched address offset: shift the wanted bytes
  // down to lane 0, then extend. Doubleword loads ignore the unsigned flag.
  always_comb begin
    rdata_shifted = dmem.dresp_rdata >> {mem_addr_q[OFF_W-1:0], 3'b000};
    load_ext      = rdata_shifted;
    case (size_q)
      2'd0: load_ext = unsigned_q ? {{(DATA_W-8){1'b0}}, rdata_shifted[7:0]}
                                  : {{(DATA_W-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'd1: load_ext = unsigned_q ? {{(DATA_W-16){1'b0}}, rdata_shifted[15:0]}
                                  : {{(DATA_W-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      2'd2: load_ext = unsigned_q ? {{(DATA_W-32){1'b0}}, rdata_shifted[31:0]}
                                  : {{(DATA_W-32){rdata_shifted[31]}}, rdata_shifted[31:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  // Next-state logic. DONE accepts a new payload exactly like IDLE so that
  // back-to-back accesses need no idle bubble. In REQ the global advance is
  // ignored and the request fields are held until the ack.
  always_comb begin
    state_d       = state_q;
    ok_d          = ok_q;
    dreq_valid_d  = dreq_valid_q;
    dreq_addr_d   = dreq_addr_q;
    dreq_write_d  = dreq_write_q;
    dreq_strobe_d = dreq_strobe_q;
    dreq_wdata_d  = dreq_wdata_q;
    out_valid_d   = out_valid_q;
    mem_out_d     = mem_out_q;
    mem_addr_d    = mem_addr_q;
    misaligned_d  = misaligned_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;

    case (state_q)
      IDLE, DONE: begin
        if (ok_to_proceed_overall) begin
          state_d      = IDLE;
          out_valid_d  = in_valid;
          mem_addr_d   = in_memAddr;
          size_d       = in_size;
          unsigned_d   = in_unsigned;
          mem_out_d    = '0;
          misaligned_d = in_valid & in_isMem & misaligned;
          if (in_valid && in_isMem && !misaligned) begin
            state_d       = REQ;
            ok_d          = 1'b0;
            dreq_valid_d  = 1'b1;
            dreq_addr_d   = {in_memAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            dreq_write_d  = ~in_isMemRead;
            dreq_strobe_d = strobe_base << in_off;
            dreq_wdata_d  = in_storeData << {in_off, 3'b000};
          end
        end
      end
      REQ: begin
        if (dmem.dresp_ack) begin
          state_d      = DONE;
          ok_d         = 1'b1;
          dreq_valid_d = 1'b0;
          if (!dreq_write_q) begin
            mem_out_d = load_ext;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      ok_q          <= 1'b1;
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= '0;
      dreq_write_q  <= 1'b0;
      dreq_strobe_q <= '0;
      dreq_wdata_q  <= '0;
      out_valid_q   <= 1'b0;
      mem_out_q     <= '0;
      mem_addr_q    <= '0;
      misaligned_q  <= 1'b0;
      size_q        <= 2'd0;
      unsigned_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ok_q          <= ok_d;
      dreq_valid_q  <= dreq_valid_d;
      dreq_addr_q   <= dreq_addr_d;
      dreq_write_q  <= dreq_write_d;
      dreq_strobe_q <= dreq_strobe_d;
      dreq_wdata_q  <= dreq_wdata_d;
      out_valid_q   <= out_valid_d;
      mem_out_q     <= mem_out_d;
      mem_addr_q    <= mem_addr_d;
      misaligned_q  <= misaligned_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
    end
  end

  assign ok_to_proceed    = ok_q;
  assign dmem.dreq_valid  = dreq_valid_q;
  assign dmem.dreq_addr   = dreq_addr_q;
  assign dmem.dreq_write  = dreq_write_q;
  assign dmem.dreq_strobe = dreq_strobe_q;
  assign dmem.dreq_wdata  = dreq_wdata_q;
  assign out_valid        = out_valid_q;
  assign out_memOut       = mem_out_q;
  assign out_memAddr      = mem_addr_q;
  assign out_misaligned   = misaligned_q;

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
// Self-checking bench for memory_access. A behavioural memory responder acks
// requests after a programmable delay; expected load results are pushed to a
// scoreboard queue when a slot is driven and popped once the stage reports
// ready again. Honours MISALIGN_TRAP_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_memory_access;

  logic        clk;
  logic        rst;
  logic        ok_to_proceed_overall;
  logic        ok_to_proceed;
  logic        in_valid;
  logic        in_isMem;
  logic        in_isMemRead;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [63:0] in_memAddr;
  logic [63:0] in_storeData;
  logic        out_valid;
  logic [63:0] out_memOut;
  logic [63:0] out_memAddr;
  logic        out_misaligned;

  memory_access_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  memory_access #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ok_to_proceed_overall (ok_to_proceed_overall),
    .ok_to_proceed         (ok_to_proceed),
    .in_valid              (in_valid),
    .in_isMem              (in_isMem),
    .in_isMemRead          (in_isMemRead),
    .in_size               (in_size),
    .in_unsigned           (in_unsigned),
    .in_memAddr            (in_memAddr),
    .in_storeData          (in_storeData),
    .dmem                  (bus.master),
    .out_valid             (out_valid),
    .out_memOut            (out_memOut),
    .out_memAddr           (out_memAddr),
    .out_misaligned        (out_misaligned)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Scoreboard of expected MEM/WB results, in issue order.
  typedef struct {
    logic [63:0] mem_out;
    logic        misaligned;
  } exp_t;
  exp_t exp_q[$];

  // Responder controls.
  bit          resp_en   = 1'b1;
  int          ack_delay = 1;
  logic [63:0] resp_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: the first negedge that sees dreq_valid counts as cycle 1 of
  // the wait; the ack pulse is raised on cycle ack_delay for one cycle.
  initial begin
    bus.dresp_ack   = 1'b0;
    bus.dresp_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_en && bus.dreq_valid === 1'b1) begin
        repeat (ack_delay - 1) @(negedge clk);
        bus.dresp_rdata = resp_data;
        bus.dresp_ack   = 1'b1;
        @(negedge clk);
        bus.dresp_ack   = 1'b0;
        bus.dresp_rdata = '0;
      end
    end
  end

  // Independent reference for load extraction, built byte by byte.
  function automatic logic [63:0] model_load(logic [63:0] rd, int off, int size, bit uns);
    int          n = 1 << size;
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) r[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!uns && size != 3 && r[8*n-1])
      for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] model_strobe(int off, int size);
    logic [7:0] s = '0;
    for (int i = 0; i < (1 << size); i++)
      if (off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  // Present one EX/MEM slot for a single advance edge; returns on the
  // negedge just after the latching edge.
  task automatic drive_slot(input bit v, input bit is_mem, input bit is_read,
                            input logic [1:0] size, input bit uns,
                            input logic [63:0] addr, input logic [63:0] sdata);
    in_valid              = v;
    in_isMem              = is_mem;
    in_isMemRead          = is_read;
    in_size               = size;
    in_unsigned           = uns;
    in_memAddr            = addr;
    in_storeData          = sdata;
    ok_to_proceed_overall = 1'b1;
    @(negedge clk);
    ok_to_proceed_overall = 1'b0;
    in_valid              = 1'b0;
  endtask

  // Count stall cycles (ok_to_proceed low), bounded so the bench cannot hang.
  task automatic wait_ready(output int low);
    low = 0;
    while (ok_to_proceed !== 1'b1 && low < 100) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (ok_to_proceed !== 1'b1) $display("[TB] FAIL reset_ok got %b expected 1", ok_to_proceed); else pass_cnt++;
    total_cnt++; if (bus.dreq_valid !== 1'b0) $display("[TB] FAIL reset_dreq_valid got %b expected 0", bus.dreq_valid); else pass_cnt++;
    total_cnt++; if (bus.dreq_strobe !== 8'h00) $display("[TB] FAIL reset_strobe got %h expected 00", bus.dreq_strobe); else pass_cnt++;
    total_cnt++; if (bus.dreq_addr !== 64'h0) $display("[TB] FAIL reset_addr got %h expected 0", bus.dreq_addr); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_memOut !== 64'h0) $display("[TB] FAIL reset_memOut got %h expected 0", out_memOut); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_byte;
    exp_t e;
    int   low;
    resp_data = 64'h1122_33FF_80AA_BBCC;
    ack_delay = 1;
    exp_q.push_back('{mem_out: 64'hFFFF_FFFF_FFFF_FF80, misaligned: 1'b0});
    drive_slot(1, 1, 1, 2'd0, 0, 64'h1003, 64'h0);
    total_cnt++; if (bus.dreq_valid !== 1'b1) $display("[TB] FAIL lb_req_valid got %b expected 1", bus.dreq_valid); else pass_cnt++;
    total_cnt++; if (bus.dreq_addr !== 64'h1000) $display("[TB] FAIL lb_addr got %h expected 1000", bus.dreq_addr); else pass_cnt++;
    total_cnt++; if (bus.dreq_write !== 1'b0) $display("[TB] FAIL lb_write got %b expected 0", bus.dreq_write); else pass_cnt++;
    total_cnt++; if (bus.dreq_strobe !== 8'h08) $display("[TB] FAIL lb_strobe got %h expected 08", bus.dreq_strobe); else pass_cnt++;
    wait_ready(low);
    total_cnt++; if (low !== 1) $display("[TB] FAIL lb_stall got %0d expected 1", low); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++; if (out_memOut !== e.mem_out) $display("[TB] FAIL lb_memOut got %h expected %h", out_memOut, e.mem_out); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL lb_out_valid got %b expected 1", out_valid); else pass_cnt++;
  endtask

  task automatic test_load_half_unsigned;
    exp_t e;
    int   low;
    resp_data = 64'h0000_0000_BEEF_0000;
    exp_q.push_back('{mem_out: 64'h0000_0000_0000_BEEF, misaligned: 1'b0});
    drive_slot(1, 1, 1, 2'd1, 1, 64'h2002, 64'h0);
    total_cnt++; if (bus.dreq_strobe !== 8'h0C) $display("[TB] FAIL lhu_strobe got %h expected 0c", bus.dreq_strobe); else pass_cnt++;
    wait_ready(low);
    e = exp_q.pop_front();
    total_cnt++; if (out_memOut !== e.mem_out) $display("[TB] FAIL lhu_memOut got %h expected %h", out_memOut, e.mem_out); else pass_cnt++;
  endtask

  task automatic test_store_word;
    exp_t e;
    int   low;
    resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_q.push_back('{mem_out: 64'h0, misaligned: 1'b0});
    drive_slot(1, 1, 0, 2'd2, 0, 64'h3004, 64'h0000_0000_1234_5678);
    total_cnt++; if (bus.dreq_strobe !== 8'hF0) $display("[TB] FAIL sw_strobe got %h expected f0", bus.dreq_strobe); else pass_cnt++;
    total_cnt++; if (bus.dreq_wdata !== 64'h1234_5678_0000_0000) $display("[TB] FAIL sw_wdata got %h expected 1234567800000000", bus.dreq_wdata); else pass_cnt++;
    total_cnt++; if (bus.dreq_addr !== 64'h3000) $display("[TB] FAIL sw_addr got %h expected 3000", bus.dreq_addr); else pass_cnt++;
    total_cnt++; if (bus.dreq_write !== 1'b1) $display("[TB] FAIL sw_write got %b expected 1", bus.dreq_write); else pass_cnt++;
    wait_ready(low);
    e = exp_q.pop_front();
    total_cnt++; if (out_memOut !== e.mem_out) $display("[TB] FAIL sw_memOut got %h expected %h", out_memOut, e.mem_out); else pass_cnt++;
  endtask

  // Five-cycle ack delay; a stray advance during REQ must not relatch.
  task automatic test_delayed_ack;
    exp_t e;
    int   low = 0;
    bit   stable = 1'b1;
    resp_data = 64'h8000_0000_0000_0001;
    ack_delay = 5;
    exp_q.push_back('{mem_out: 64'h8000_0000_0000_0001, misaligned: 1'b0});
    drive_slot(1, 1, 1, 2'd3, 1, 64'h5008, 64'h0);
    while (ok_to_proceed !== 1'b1 && low < 100) begin
      low++;
      if (bus.dreq_valid !== 1'b1 || bus.dreq_addr !== 64'h5008 ||
          bus.dreq_strobe !== 8'hFF || bus.dreq_write !== 1'b0) stable = 1'b0;
      if (low == 2) begin
        ok_to_proceed_overall = 1'b1;
        in_valid = 1'b1; in_isMem = 1'b1; in_memAddr = 64'hDEAD_0000;
      end
      if (low == 3) begin
        ok_to_proceed_overall = 1'b0;
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    ack_delay = 1;
    total_cnt++; if (low !== 5) $display("[TB] FAIL delay_stall got %0d expected 5", low); else pass_cnt++;
    total_cnt++; if (stable !== 1'b1) $display("[TB] FAIL delay_stable got %b expected 1", stable); else pass_cnt++;
    total_cnt++; if (out_memAddr !== 64'h5008) $display("[TB] FAIL delay_no_relatch got %h expected 5008", out_memAddr); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++; if (out_memOut !== e.mem_out) $display("[TB] FAIL ld_memOut got %h expected %h", out_memOut, e.mem_out); else pass_cnt++;
    total_cnt++; if (bus.dreq_valid !== 1'b0) $display("[TB] FAIL delay_req_drop got %b expected 0", bus.dreq_valid); else pass_cnt++;
  endtask

  // Valid but non-memory slot: no request, dreq fields untouched.
  task automatic test_non_mem;
    drive_slot(1, 0, 1, 2'd2, 0, 64'h9000, 64'hAAAA);
    total_cnt++; if (bus.dreq_valid !== 1'b0) $display("[TB] FAIL nonmem_req got %b expected 0", bus.dreq_valid); else pass_cnt++;
    total_cnt++; if (ok_to_proceed !== 1'b1) $display("[TB] FAIL nonmem_ok got %b expected 1", ok_to_proceed); else pass_cnt++;
    total_cnt++; if (out_memAddr !== 64'h9000) $display("[TB] FAIL nonmem_addr got %h expected 9000", out_memAddr); else pass_cnt++;
    total_cnt++; if (out_memOut !== 64'h0) $display("[TB] FAIL nonmem_memOut got %h expected 0", out_memOut); else pass_cnt++;
    total_cnt++; if (bus.dreq_addr !== 64'h5008) $display("[TB] FAIL nonmem_dreq_hold got %h expected 5008", bus.dreq_addr); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   low;
    resp_data = 64'h7FFF_FFFF_0000_0000;
    exp_q.push_back('{mem_out: 64'h0000_0000_7FFF_FFFF, misaligned: 1'b0});
    drive_slot(1, 1, 1, 2'd2, 0, 64'h6004, 64'h0);
    wait_ready(low);
    e = exp_q.pop_front();
    total_cnt++; if (out_memOut !== e.mem_out) $display("[TB] FAIL b2b_first got %h expected %h", out_memOut, e.mem_out); else pass_cnt++;
    resp_data = 64'hAB00_0000_0000_0000;
    exp_q.push_back('{mem_out: 64'h0000_0000_0000_00AB, misaligned: 1'b0});
    drive_slot(1, 1, 1, 2'd0, 1, 64'h6007, 64'h0);
    total_cnt++; if (bus.dreq_valid !== 1'b1) $display("[TB] FAIL b2b_second_req got %b expected 1", bus.dreq_valid); else pass_cnt++;
    wait_ready(low);
    total_cnt++; if (low !== 1) $display("[TB] FAIL b2b_stall got %0d expected 1", low); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++; if (out_memOut !== e.mem_out) $display("[TB] FAIL b2b_second got %h expected %h", out_memOut, e.mem_out); else pass_cnt++;
  endtask

  task automatic test_misaligned;
    exp_t e;
    int   low;
    bit   saw_req = 1'b0;
    resp_data = 64'h0000_8765_4321_0000;
`ifdef MISALIGN_TRAP_EN
    exp_q.push_back('{mem_out: 64'h0, misaligned: 1'b1});
`else
    exp_q.push_back('{mem_out: 64'hFFFF_FFFF_8765_4321, misaligned: 1'b0});
`endif
    drive_slot(1, 1, 1, 2'd2, 0, 64'h4002, 64'h0);
`ifdef MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      if (bus.dreq_valid !== 1'b0 || ok_to_proceed !== 1'b1) saw_req = 1'b1;
      @(negedge clk);
    end
`else
    saw_req = (bus.dreq_valid === 1'b1);
    total_cnt++; if (bus.dreq_strobe !== 8'h3C) $display("[TB] FAIL mis_strobe got %h expected 3c", bus.dreq_strobe); else pass_cnt++;
`endif
    wait_ready(low);
`ifdef MISALIGN_TRAP_EN
    total_cnt++; if (saw_req !== 1'b0) $display("[TB] FAIL mis_trap_req got %b expected 0", saw_req); else pass_cnt++;
`else
    total_cnt++; if (saw_req !== 1'b1) $display("[TB] FAIL mis_issue_req got %b expected 1", saw_req); else pass_cnt++;
`endif
    e = exp_q.pop_front();
    total_cnt++; if (out_misaligned !== e.misaligned) $display("[TB] FAIL mis_flag got %b expected %b", out_misaligned, e.misaligned); else pass_cnt++;
    total_cnt++; if (out_memOut !== e.mem_out) $display("[TB] FAIL mis_memOut got %h expected %h", out_memOut, e.mem_out); else pass_cnt++;
  endtask

  // Aligned random loads of every size, checked against the byte-wise model.
  task automatic test_random_loads;
    exp_t        e;
    int          low, size, off;
    bit          uns;
    logic [7:0]  exp_strb;
    for (int k = 0; k < 8; k++) begin
      size      = $urandom_range(0, 3);
      off       = $urandom_range(0, 7) & ~((1 << size) - 1);
      uns       = 1'($urandom_range(0, 1));
      resp_data = {$urandom, $urandom};
      exp_strb  = model_strobe(off, size);
      exp_q.push_back('{mem_out: model_load(resp_data, off, size, uns), misaligned: 1'b0});
      drive_slot(1, 1, 1, 2'(size), uns, 64'hA000 + 64'(off), 64'h0);
      total_cnt++; if (bus.dreq_strobe !== exp_strb) $display("[TB] FAIL rnd_strobe got %h expected %h", bus.dreq_strobe, exp_strb); else pass_cnt++;
      wait_ready(low);
      e = exp_q.pop_front();
      total_cnt++; if (out_memOut !== e.mem_out) $display("[TB] FAIL rnd_memOut got %h expected %h", out_memOut, e.mem_out); else pass_cnt++;
    end
  endtask

  // Reset in the middle of REQ, then a stray ack that must be ignored.
  task automatic test_reset_in_req;
    resp_en = 1'b0;
    drive_slot(1, 1, 0, 2'd3, 0, 64'h7000, 64'h5555_5555_5555_5555);
    total_cnt++; if (bus.dreq_valid !== 1'b1) $display("[TB] FAIL rr_req got %b expected 1", bus.dreq_valid); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.dresp_ack   = 1'b1;
    bus.dresp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    bus.dresp_ack   = 1'b0;
    bus.dresp_rdata = '0;
    total_cnt++; if (bus.dreq_valid !== 1'b0) $display("[TB] FAIL rr_req_drop got %b expected 0", bus.dreq_valid); else pass_cnt++;
    total_cnt++; if (ok_to_proceed !== 1'b1) $display("[TB] FAIL rr_ok got %b expected 1", ok_to_proceed); else pass_cnt++;
    total_cnt++; if (bus.dreq_wdata !== 64'h0) $display("[TB] FAIL rr_wdata got %h expected 0", bus.dreq_wdata); else pass_cnt++;
    total_cnt++; if (bus.dreq_write !== 1'b0) $display("[TB] FAIL rr_write got %b expected 0", bus.dreq_write); else pass_cnt++;
    total_cnt++; if (out_memAddr !== 64'h0) $display("[TB] FAIL rr_memAddr got %h expected 0", out_memAddr); else pass_cnt++;
    total_cnt++; if (out_memOut !== 64'h0) $display("[TB] FAIL rr_memOut got %h expected 0", out_memOut); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ok_to_proceed !== 1'b1) $display("[TB] FAIL rr_ok_hold got %b expected 1", ok_to_proceed); else pass_cnt++;
    resp_en = 1'b1;
  endtask

  initial begin
    rst                   = 1'b0;
    ok_to_proceed_overall = 1'b0;
    in_valid              = 1'b0;
    in_isMem              = 1'b0;
    in_isMemRead          = 1'b0;
    in_size               = 2'd0;
    in_unsigned           = 1'b0;
    in_memAddr            = '0;
    in_storeData          = '0;
    @(negedge clk);
    test_reset;
    test_load_byte;
    test_load_half_unsigned;
    test_store_word;
    test_delayed_ack;
    test_non_mem;
    test_back_to_back;
    test_misaligned;
    test_random_loads;
    test_reset_in_req;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
